// File: rtl/pipe_add_sub_pkg.sv
// pipe_add_sub_pkg: shared constants for the segmented add/sub pipeline.
// Holds the op encoding and the bit positions inside the 4-bit flags bus.
package pipe_add_sub_pkg;

  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_SUB    = 2'b01;
  localparam logic [1:0] OP_ADC    = 2'b10;
  localparam logic [1:0] OP_SATADD = 2'b11;

  // flags = {CF, VF, ZF, NF}
  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 0;

endpackage

// File: rtl/pipe_add_sub_cla_seg.sv
// cla_seg: SEG-bit carry-lookahead adder segment.
// c_msb is the carry into the top bit, used for signed-overflow detection.
module cla_seg #(
  parameter int unsigned SEG = 16
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb
);

  logic [SEG-1:0] g;
  logic [SEG-1:0] p;
  logic [SEG:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is the flattened sum-of-products over all lower generates and ci.
  always_comb begin
    logic gg;
    logic pp;
    c    = '0;
    gg   = 1'b0;
    pp   = 1'b0;
    c[0] = ci;
    for (int i = 0; i < int'(SEG); i++) begin
      gg = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        gg = gg | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = gg | (pp & ci);
    end
  end

  assign s     = p ^ c[SEG-1:0];
  assign co    = c[SEG];
  assign c_msb = c[SEG-1];

endmodule

// File: rtl/pipe_add_sub.sv
// pipe_add_sub: WIDTH-bit add/sub/adc/satadd pipelined in SEG-bit segments,
// one segment per stage, with valid/ready flow control over the whole pipe.
// Define PIPE_ADD_SUB_SAT_EN to enable saturation for op=11; otherwise op=11 is ADD.
module pipe_add_sub
  import pipe_add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [3:0]       flags
);

  localparam int unsigned STAGES = WIDTH / SEG;

  // Register bank k holds the state leaving stage k; bank STAGES-1 is the output.
  logic             v_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] r_q [STAGES];
  logic             c_q [STAGES];
  logic             z_q [STAGES];
`ifdef PIPE_ADD_SUB_SAT_EN
  logic             sat_q [STAGES];
  logic             sat_0;
`endif
  logic [3:0]       flags_q;
  logic [WIDTH-1:0] b_0;
  logic             c_0;
  logic             adv;

  assign out_valid = v_q[STAGES-1];
  assign in_ready  = !out_valid || out_ready;
  assign adv       = in_ready;
  assign sum       = r_q[STAGES-1];
  assign flags     = flags_q;

  // Stage-0 operand conditioning: SUB becomes A + ~B + 1.
  always_comb begin
    b_0 = B;
    c_0 = 1'b0;
    case (op)
      OP_SUB: begin
        b_0 = ~B;
        c_0 = 1'b1;
      end
      OP_ADC:  c_0 = cin;
      default: ;
    endcase
  end

`ifdef PIPE_ADD_SUB_SAT_EN
  assign sat_0 = (op == OP_SATADD);
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             v_i, c_i, z_i;
    logic [WIDTH-1:0] a_i, b_i, r_i;
    logic [SEG-1:0]   s;
    logic             co, c_msb;
    logic [WIDTH-1:0] r_nx, r_st;
    logic             z_nx, z_st;
`ifdef PIPE_ADD_SUB_SAT_EN
    logic             sat_i;
`endif

    if (k == 0) begin : g_in
      assign v_i = in_valid;
      assign a_i = A;
      assign b_i = b_0;
      assign r_i = '0;
      assign c_i = c_0;
      assign z_i = 1'b1;
`ifdef PIPE_ADD_SUB_SAT_EN
      assign sat_i = sat_0;
`endif
    end else begin : g_in
      assign v_i = v_q[k-1];
      assign a_i = a_q[k-1];
      assign b_i = b_q[k-1];
      assign r_i = r_q[k-1];
      assign c_i = c_q[k-1];
      assign z_i = z_q[k-1];
`ifdef PIPE_ADD_SUB_SAT_EN
      assign sat_i = sat_q[k-1];
`endif
    end

    cla_seg #(
      .SEG (SEG)
    ) u_seg (
      .a     (a_i[k*SEG +: SEG]),
      .b     (b_i[k*SEG +: SEG]),
      .ci    (c_i),
      .s     (s),
      .co    (co),
      .c_msb (c_msb)
    );

    // Splice this segment into the running result and accumulate zero detect.
    always_comb begin
      r_nx              = r_i;
      r_nx[k*SEG +: SEG] = s;
      z_nx              = z_i & ~|s;
    end

    if (k == STAGES - 1) begin : g_out
      logic             vf;
      logic [WIDTH-1:0] r_fin;
      logic             z_fin;

      assign vf = c_msb ^ co;

      // Final segment: optional clamp; a clamped value is never zero.
      always_comb begin
        r_fin = r_nx;
        z_fin = z_nx;
`ifdef PIPE_ADD_SUB_SAT_EN
        if (sat_i && vf) begin
          r_fin = {a_i[WIDTH-1], {(WIDTH-1){~a_i[WIDTH-1]}}};
          z_fin = 1'b0;
        end
`endif
      end

      assign r_st = r_fin;
      assign z_st = z_fin;

      // Flags are formed once the MSB segment is known.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          flags_q <= '0;
        end else if (adv) begin
          flags_q[FLAG_C] <= co;
          flags_q[FLAG_V] <= vf;
          flags_q[FLAG_Z] <= z_fin;
          flags_q[FLAG_N] <= r_fin[WIDTH-1];
        end
      end
    end else begin : g_mid
      assign r_st = r_nx;
      assign z_st = z_nx;
    end

    // Stage register bank; whole pipe holds together when downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
        c_q[k] <= 1'b0;
        z_q[k] <= 1'b0;
`ifdef PIPE_ADD_SUB_SAT_EN
        sat_q[k] <= 1'b0;
`endif
      end else if (adv) begin
        v_q[k] <= v_i;
        a_q[k] <= a_i;
        b_q[k] <= b_i;
        r_q[k] <= r_st;
        c_q[k] <= co;
        z_q[k] <= z_st;
`ifdef PIPE_ADD_SUB_SAT_EN
        sat_q[k] <= sat_i;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pipe_add_sub.sv
// tb_pipe_add_sub: self-checking bench for pipe_add_sub (WIDTH=32, SEG=16).
// Reference model uses plain 33-bit arithmetic; honours PIPE_ADD_SUB_SAT_EN.
module tb_pipe_add_sub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic        cin;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic [35:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_add_sub #(
    .WIDTH (32),
    .SEG   (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .cin       (cin),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .flags     (flags)
  );

  // Expected {sum, CF, VF, ZF, NF} from the arithmetic definition.
  function automatic logic [35:0] model(input logic [1:0] o, input logic c,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] bb;
    logic        ci;
    logic [32:0] full;
    logic [31:0] s;
    logic        cf, vf;
    bb   = (o == 2'b01) ? ~b : b;
    ci   = (o == 2'b01) ? 1'b1 : ((o == 2'b10) ? c : 1'b0);
    full = {1'b0, a} + {1'b0, bb} + 33'(ci);
    s    = full[31:0];
    cf   = full[32];
    vf   = (a[31] == bb[31]) && (s[31] != a[31]);
`ifdef PIPE_ADD_SUB_SAT_EN
    if (o == 2'b11 && vf) s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {s, cf, vf, (s == 32'h0), s[31]};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_FFFF;
      4: return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  // One clock of stimulus with scoreboard checking of whatever is at the output.
  task automatic step(input logic v, input logic [1:0] o, input logic c,
                      input logic [31:0] a, input logic [31:0] b, input logic rdy,
                      output logic acc);
    logic fo;
    @(negedge clk);
    in_valid  = v;
    op        = o;
    cin       = c;
    A         = a;
    B         = b;
    out_ready = rdy;
    #1;
    checks++;
    if (in_ready !== (!out_valid || rdy)) begin
      errors++;
      $display("FAIL in_ready: got %b, expected %b (out_valid=%b out_ready=%b)",
               in_ready, !out_valid || rdy, out_valid, rdy);
    end
    fo = 1'b0;
    if (out_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_result: got sum=%h flags=%b, expected no valid output",
                 sum, flags);
      end else if ({sum, flags} !== exp_q[0]) begin
        errors++;
        $display("FAIL result: got sum=%h flags=%b, expected sum=%h flags=%b",
                 sum, flags, exp_q[0][35:4], exp_q[0][3:0]);
      end
      fo = rdy;
    end
    acc = v && in_ready;
    @(posedge clk);
    if (fo && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      pops++;
    end
    if (acc) exp_q.push_back(model(o, c, a, b));
  endtask

  task automatic drain(input string name);
    logic acc;
    int   n;
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      step(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, acc);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d results still outstanding, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 2'b00;
    cin       = 1'b0;
    A         = '0;
    B         = '0;
    out_ready = 1'b1;
    #12;
    checks += 4;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b, expected 0", out_valid);
    end
    if (sum !== 32'h0) begin
      errors++;
      $display("FAIL reset_sum: got %h, expected 0", sum);
    end
    if (flags !== 4'h0) begin
      errors++;
      $display("FAIL reset_flags: got %b, expected 0000", flags);
    end
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Directed vectors with exact 2-cycle latency; first beat meets the first edge after reset.
  task automatic test_directed();
    logic [1:0]  t_op   [7];
    logic        t_cin  [7];
    logic [31:0] t_a    [7];
    logic [31:0] t_b    [7];
    logic [31:0] t_sum  [7];
    logic [3:0]  t_flg  [7];
    t_op[0] = 2'b00; t_cin[0] = 0; t_a[0] = 32'h0000_FFFF; t_b[0] = 32'h1;
    t_sum[0] = 32'h0001_0000; t_flg[0] = 4'b0000;
    t_op[1] = 2'b01; t_cin[1] = 0; t_a[1] = 32'h5; t_b[1] = 32'h5;
    t_sum[1] = 32'h0; t_flg[1] = 4'b1010;
    t_op[2] = 2'b01; t_cin[2] = 0; t_a[2] = 32'h0; t_b[2] = 32'h1;
    t_sum[2] = 32'hFFFF_FFFF; t_flg[2] = 4'b0001;
    t_op[3] = 2'b11; t_cin[3] = 0; t_a[3] = 32'h7FFF_FFFF; t_b[3] = 32'h1;
`ifdef PIPE_ADD_SUB_SAT_EN
    t_sum[3] = 32'h7FFF_FFFF; t_flg[3] = 4'b0100;
`else
    t_sum[3] = 32'h8000_0000; t_flg[3] = 4'b0101;
`endif
    t_op[4] = 2'b10; t_cin[4] = 1; t_a[4] = 32'hFFFF_FFFF; t_b[4] = 32'h0;
    t_sum[4] = 32'h0; t_flg[4] = 4'b1010;
    // cin must be ignored for plain ADD
    t_op[5] = 2'b00; t_cin[5] = 1; t_a[5] = 32'h1234_5678; t_b[5] = 32'h1111_1111;
    t_sum[5] = 32'h2345_6789; t_flg[5] = 4'b0000;
    t_op[6] = 2'b00; t_cin[6] = 0; t_a[6] = 32'h8000_0000; t_b[6] = 32'h8000_0000;
    t_sum[6] = 32'h0; t_flg[6] = 4'b1110;
    for (int i = 0; i < 7; i++) begin
      in_valid  = 1'b1;
      op        = t_op[i];
      cin       = t_cin[i];
      A         = t_a[i];
      B         = t_b[i];
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_in_ready: got %b, expected 1", i, in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_early_valid: got %b, expected 0 after 1 cycle", i, out_valid);
      end
      @(negedge clk);
      #1;
      checks += 3;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_latency: got out_valid=%b, expected 1 after 2 cycles", i, out_valid);
      end
      if (sum !== t_sum[i]) begin
        errors++;
        $display("FAIL dir%0d_sum: got %h, expected %h", i, sum, t_sum[i]);
      end
      if (flags !== t_flg[i]) begin
        errors++;
        $display("FAIL dir%0d_flags: got %b, expected %b", i, flags, t_flg[i]);
      end
    end
    @(posedge clk);
  endtask

  task automatic test_back_to_back();
    logic acc;
    int   idx;
    logic [31:0] va [4];
    logic [31:0] vb [4];
    for (int i = 0; i < 4; i++) begin
      va[i] = $urandom;
      vb[i] = $urandom;
    end
    pops = 0;
    idx  = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      step(idx < 4, 2'(idx), 1'b1, va[idx % 4], vb[idx % 4], !(cyc >= 3 && cyc <= 5), acc);
      if (cyc >= 3 && cyc <= 5) begin
        checks++;
        if (acc !== 1'b0) begin
          errors++;
          $display("FAIL b2b_stall_cycle%0d: beat accepted=%b, expected 0", cyc, acc);
        end
      end
      if (acc) idx++;
    end
    drain("b2b");
    checks += 2;
    if (idx != 4) begin
      errors++;
      $display("FAIL b2b_accepted: got %0d beats, expected 4", idx);
    end
    if (pops != 4) begin
      errors++;
      $display("FAIL b2b_emitted: got %0d results, expected 4", pops);
    end
  endtask

  task automatic test_random();
    logic acc;
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           pick_operand(), pick_operand(), $urandom_range(0, 3) != 0, acc);
    end
    drain("random");
  endtask

  task automatic test_reset_inflight();
    logic acc;
    step(1'b1, 2'b00, 1'b0, 32'h1111_1111, 32'h2222_2222, 1'b1, acc);
    step(1'b1, 2'b01, 1'b0, 32'h9999_9999, 32'h1111_1111, 1'b1, acc);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_inflight_out_valid: got %b, expected 0", out_valid);
    end
    if (sum !== 32'h0) begin
      errors++;
      $display("FAIL rst_inflight_sum: got %h, expected 0", sum);
    end
    if (flags !== 4'h0) begin
      errors++;
      $display("FAIL rst_inflight_flags: got %b, expected 0000", flags);
    end
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_inflight_in_ready: got %b, expected 1", in_ready);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    // Any valid output now is a stale beat and flagged as spurious by step.
    for (int n = 0; n < 6; n++) step(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, acc);
    step(1'b1, 2'b10, 1'b1, 32'h0000_FFFF, 32'hFFFF_0000, 1'b1, acc);
    drain("post_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
